// File: rtl/uart_pkg.sv
// Shared definitions for the UART console arbiter: register map, status bits
// and the arbiter FSM state type.
package uart_pkg;

  localparam logic [31:0] UART_STATUS_OFS  = 32'd0;
  localparam logic [31:0] UART_RX_OFS      = 32'd4;
  localparam logic [31:0] UART_TX_OFS      = 32'd8;
  localparam logic [31:0] UART_DIVISOR_OFS = 32'd12;

  localparam int TX_READY  = 0;
  localparam int RX_AVAIL  = 1;
  localparam int OVERRUN   = 2;
  localparam int FRAME_ERR = 3;

  typedef enum logic [2:0] {INIT, IDLE, POLL, CHECK, WRITE} uart_arb_state_t;

endpackage

// File: rtl/io_bus_interface.sv
// Simple memory-mapped io_bus: one read or write per cycle, 32-bit data.
interface io_bus_interface;

  logic [31:0] address;
  logic        read_en;
  logic        write_en;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (output address, read_en, write_en, write_data, input read_data);
  modport slave  (input address, read_en, write_en, write_data, output read_data);

endinterface

// File: rtl/uart_console_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from the slot
// after the last grant; the pointer advances only on a strobed grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         request,
  input  logic                 grant_strobe,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] last_idx
);

  localparam int IW = $clog2(N);

  int cand;

  // Walk the N slots starting just past last_idx, wrapping, and take the first hit.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(last_idx) + k;
      if (cand >= N) cand = cand - N;
      if (!grant_valid && request[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

  // Pointer resets to the top slot so the first search starts at requester 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_idx <= IW'(N - 1);
    end else if (grant_strobe && grant_valid) begin
      last_idx <= grant_idx;
    end
  end

endmodule

// File: rtl/uart_console_arbiter.sv
// Serializes characters from several console requesters into one UART TX
// register, keeping each requester's line together until it sends a newline.
module uart_console_arbiter
  import uart_pkg::*;
#(
  parameter int          NUM_REQUESTERS = 4,
  parameter logic [31:0] UART_BASE      = 32'h0,
  parameter logic [15:0] INIT_DIVISOR   = 16'd27,
  parameter int          LOCK_TIMEOUT   = 1024
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQUESTERS-1:0]           req_valid,
  input  logic [NUM_REQUESTERS-1:0][7:0]      req_char,
  output logic [NUM_REQUESTERS-1:0]           req_ready,
  io_bus_interface.master                     io_bus,
  output logic [$clog2(NUM_REQUESTERS)-1:0]   grant_id,
  output logic                                line_locked
);

  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  uart_arb_state_t state, next_state;

  logic [NUM_REQUESTERS-1:0]         eligible, holder_mask, arb_grant;
  logic [$clog2(NUM_REQUESTERS)-1:0] arb_idx;
  logic                              arb_valid;
  logic [7:0]                        char_reg;
  logic [CW-1:0]                     lock_count, lock_count_inc;
  logic                              lock_counting;

  logic [NUM_REQUESTERS-1:0] nxt_req_ready;
  logic [31:0]               nxt_address, nxt_write_data;
  logic                      nxt_read_en, nxt_write_en;
  logic [31:0]               address_q, write_data_q;
  logic                      read_en_q, write_en_q;

  // While a line is open only its owner may be picked.
  always_comb begin
    holder_mask           = '0;
    holder_mask[grant_id] = 1'b1;
    eligible              = line_locked ? (req_valid & holder_mask) : req_valid;
  end

  rr_arbiter #(.N(NUM_REQUESTERS)) u_rr (
    .clk          (clk),
    .reset        (reset),
    .request      (eligible),
    .grant_strobe (state == IDLE),
    .grant        (arb_grant),
    .grant_idx    (arb_idx),
    .grant_valid  (arb_valid),
    .last_idx     (grant_id)
  );

  assign lock_counting  = (state == IDLE) && line_locked && !req_valid[grant_id];
  assign lock_count_inc = lock_count + CW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= INIT;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      INIT:    next_state = IDLE;
      IDLE:    next_state = arb_valid ? POLL : IDLE;
      POLL:    next_state = CHECK;
      CHECK:   next_state = io_bus.read_data[TX_READY] ? WRITE : POLL;
      WRITE:   next_state = IDLE;
      default: next_state = INIT;
    endcase
  end

  // Bus actions are decided per state here and registered below, so they
  // appear on io_bus in the cycle after the state that requested them.
  always_comb begin
    nxt_req_ready  = '0;
    nxt_address    = '0;
    nxt_read_en    = 1'b0;
    nxt_write_en   = 1'b0;
    nxt_write_data = '0;
    case (state)
      INIT: begin
        nxt_write_en   = 1'b1;
        nxt_address    = UART_BASE + UART_DIVISOR_OFS;
        nxt_write_data = {16'b0, INIT_DIVISOR};
      end
      IDLE:  nxt_req_ready = arb_grant;
      POLL: begin
        nxt_read_en = 1'b1;
        nxt_address = UART_BASE + UART_STATUS_OFS;
      end
      WRITE: begin
        nxt_write_en   = 1'b1;
        nxt_address    = UART_BASE + UART_TX_OFS;
        nxt_write_data = {24'b0, char_reg};
      end
      default: ;
    endcase
  end

  // A newline closes the line; an idle owner loses the lock after LOCK_TIMEOUT cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ready    <= '0;
      address_q    <= '0;
      read_en_q    <= 1'b0;
      write_en_q   <= 1'b0;
      write_data_q <= '0;
      char_reg     <= '0;
      line_locked  <= 1'b0;
      lock_count   <= '0;
    end else begin
      req_ready    <= nxt_req_ready;
      address_q    <= nxt_address;
      read_en_q    <= nxt_read_en;
      write_en_q   <= nxt_write_en;
      write_data_q <= nxt_write_data;
      if (state == IDLE && arb_valid) begin
        char_reg    <= req_char[arb_idx];
        line_locked <= (req_char[arb_idx] != 8'h0A);
        lock_count  <= '0;
      end else if (lock_counting) begin
        if (lock_count_inc == CW'(LOCK_TIMEOUT)) begin
          line_locked <= 1'b0;
          lock_count  <= '0;
        end else begin
          lock_count <= lock_count_inc;
        end
      end
    end
  end

  assign io_bus.address    = address_q;
  assign io_bus.read_en    = read_en_q;
  assign io_bus.write_en   = write_en_q;
  assign io_bus.write_data = write_data_q;

endmodule

// File: tb/tb_uart_console_arbiter.sv
// Directed self-checking bench for uart_console_arbiter with a small UART
// status model and per-requester character FIFOs.
module tb_uart_console_arbiter;

  localparam int          NUM         = 4;
  localparam logic [31:0] BASE        = 32'h4000_0100;
  localparam logic [31:0] ADDR_STATUS = 32'h4000_0100;
  localparam logic [31:0] ADDR_TX     = 32'h4000_0108;
  localparam logic [31:0] ADDR_DIV    = 32'h4000_010C;
  localparam int          LOCK_TO     = 20;

  logic                clk = 1'b0;
  logic                reset;
  logic [NUM-1:0]      req_valid;
  logic [NUM-1:0][7:0] req_char;
  logic [NUM-1:0]      req_ready;
  logic [1:0]          grant_id;
  logic                line_locked;
  logic                tx_ready;

  io_bus_interface io_bus ();

  // The status register answers in the same cycle it is read.
  assign io_bus.read_data = (io_bus.read_en && io_bus.address == ADDR_STATUS) ?
                            {31'b0, tx_ready} : 32'h0;

  uart_console_arbiter #(
    .NUM_REQUESTERS (NUM),
    .UART_BASE      (BASE),
    .INIT_DIVISOR   (16'd27),
    .LOCK_TIMEOUT   (LOCK_TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_char    (req_char),
    .req_ready   (req_ready),
    .io_bus      (io_bus),
    .grant_id    (grant_id),
    .line_locked (line_locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  fifo_mem [NUM][16];
  int          fifo_head [NUM];
  int          fifo_tail [NUM];
  logic [15:0] write_log [32];
  int          write_count;
  int          grant_log [32];
  int          grant_count;

  logic [15:0] stream_expect [6] = '{16'h0041, 16'h0042, 16'h000A,
                                     16'h0241, 16'h0242, 16'h020A};
  int          rotate_expect [5] = '{0, 1, 2, 3, 0};

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic drive_requesters();
    for (int i = 0; i < NUM; i++) begin
      req_valid[i] = (fifo_head[i] < fifo_tail[i]);
      req_char[i]  = req_valid[i] ? fifo_mem[i][fifo_head[i]] : 8'h00;
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] ch);
    if (fifo_tail[idx] < 16) begin
      fifo_mem[idx][fifo_tail[idx]] = ch;
      fifo_tail[idx]++;
    end
    drive_requesters();
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < NUM; i++) begin
      fifo_head[i] = 0;
      fifo_tail[i] = 0;
    end
    write_count = 0;
    grant_count = 0;
    drive_requesters();
  endtask

  // One clock: sample just after the edge, log handshakes and TX writes, refresh requesters.
  task automatic step_cycle();
    @(posedge clk);
    #1;
    if (!reset) begin
      for (int i = 0; i < NUM; i++) begin
        if (req_ready[i]) begin
          if (fifo_head[i] < fifo_tail[i]) fifo_head[i]++;
          if (grant_count < 32) begin
            grant_log[grant_count] = i;
            grant_count++;
          end
        end
      end
      if (io_bus.write_en && io_bus.address == ADDR_TX && write_count < 32) begin
        write_log[write_count] = {6'b0, grant_id, io_bus.write_data[7:0]};
        write_count++;
      end
    end
    drive_requesters();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_fifos();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int reads;
    int writes_before;
    int stray;
    logic found;

    tx_ready = 1'b1;
    do_reset();
    applyStimulus(1, 8'h41);

    checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_read_en", 32'(io_bus.read_en), 32'h0);
    checkOutput("rst_write_en", 32'(io_bus.write_en), 32'h0);
    checkOutput("rst_address", io_bus.address, 32'h0);
    checkOutput("rst_write_data", io_bus.write_data, 32'h0);
    checkOutput("rst_grant_id", 32'(grant_id), 32'd3);
    checkOutput("rst_line_locked", 32'(line_locked), 32'h0);

    reset = 1'b0;
    step_cycle();
    checkOutput("init_write_en", 32'(io_bus.write_en), 32'h1);
    checkOutput("init_address", io_bus.address, ADDR_DIV);
    checkOutput("init_data", io_bus.write_data, 32'd27);
    checkOutput("init_no_grant", 32'(req_ready), 32'h0);
    step_cycle();
    checkOutput("a_req_ready", 32'(req_ready), 32'b0010);
    checkOutput("a_grant_id", 32'(grant_id), 32'd1);
    checkOutput("a_locked", 32'(line_locked), 32'h1);
    step_cycle();
    checkOutput("a_poll_read_en", 32'(io_bus.read_en), 32'h1);
    checkOutput("a_poll_address", io_bus.address, ADDR_STATUS);
    checkOutput("a_poll_write_en", 32'(io_bus.write_en), 32'h0);
    step_cycle();
    checkOutput("a_check_quiet", 32'({io_bus.read_en, io_bus.write_en, |req_ready}), 32'h0);
    step_cycle();
    checkOutput("a_tx_write_en", 32'(io_bus.write_en), 32'h1);
    checkOutput("a_tx_address", io_bus.address, ADDR_TX);
    checkOutput("a_tx_data", io_bus.write_data, 32'h41);

    // Newline from the lock holder while the transmitter stays busy.
    tx_ready = 1'b0;
    applyStimulus(1, 8'h0A);
    step_cycle();
    checkOutput("nl_req_ready", 32'(req_ready), 32'b0010);
    checkOutput("nl_unlocked", 32'(line_locked), 32'h0);
    reads = 0;
    writes_before = write_count;
    for (int c = 0; c < 10; c++) begin
      step_cycle();
      if (io_bus.read_en) reads++;
    end
    checkOutput("busy_read_pulses", 32'(reads), 32'd5);
    checkOutput("busy_no_tx", 32'(write_count - writes_before), 32'd0);
    tx_ready = 1'b1;
    n = 0;
    found = 1'b0;
    while (!found && n < 20) begin
      step_cycle();
      n++;
      if (io_bus.write_en && io_bus.address == ADDR_TX) found = 1'b1;
    end
    checkOutput("ready_tx_latency", 32'(n), 32'd3);
    checkOutput("ready_tx_data", io_bus.write_data, 32'h0A);
    step_cycle();
    checkOutput("ready_single_write", 32'(io_bus.write_en), 32'h0);

    // Two requesters stream whole lines concurrently.
    do_reset();
    for (int i = 0; i <= 2; i += 2) begin
      applyStimulus(i, 8'h41);
      applyStimulus(i, 8'h42);
      applyStimulus(i, 8'h0A);
    end
    reset = 1'b0;
    n = 0;
    while (write_count < 6 && n < 200) begin
      step_cycle();
      n++;
    end
    checkOutput("stream_write_count", 32'(write_count), 32'd6);
    for (int k = 0; k < 6; k++)
      checkOutput($sformatf("stream_%0d", k), 32'(write_log[k]), 32'(stream_expect[k]));

    // Lock holder goes quiet; another requester waits for the timeout.
    do_reset();
    applyStimulus(0, 8'h41);
    applyStimulus(3, 8'h0A);
    reset = 1'b0;
    n = 0;
    found = 1'b0;
    while (!found && n < 50) begin
      step_cycle();
      n++;
      if (io_bus.write_en && io_bus.address == ADDR_TX) found = 1'b1;
    end
    checkOutput("lock_a_written", 32'(found), 32'h1);
    checkOutput("lock_a_owner", 32'(grant_id), 32'd0);
    stray = 0;
    for (int k = 1; k <= 19; k++) begin
      step_cycle();
      if (|req_ready) stray++;
    end
    checkOutput("lock_held_at_19", 32'(line_locked), 32'h1);
    step_cycle();
    if (|req_ready) stray++;
    checkOutput("lock_dropped_at_20", 32'(line_locked), 32'h0);
    checkOutput("lock_no_grant_while_held", 32'(stray), 32'd0);
    step_cycle();
    checkOutput("lock_next_req_ready", 32'(req_ready), 32'b1000);
    checkOutput("lock_next_grant_id", 32'(grant_id), 32'd3);

    // Everyone sends newlines: plain rotation, then reset during CHECK.
    do_reset();
    for (int i = 0; i < NUM; i++)
      for (int r = 0; r < 3; r++) applyStimulus(i, 8'h0A);
    reset = 1'b0;
    n = 0;
    while (grant_count < 5 && n < 100) begin
      step_cycle();
      n++;
    end
    checkOutput("rotate_count", 32'(grant_count), 32'd5);
    for (int k = 0; k < 5; k++)
      checkOutput($sformatf("rotate_%0d", k), 32'(grant_log[k]), 32'(rotate_expect[k]));
    step_cycle();
    checkOutput("midrst_in_check", 32'(io_bus.read_en), 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("midrst_req_ready", 32'(req_ready), 32'h0);
    checkOutput("midrst_bus", 32'({io_bus.read_en, io_bus.write_en}), 32'h0);
    checkOutput("midrst_address", io_bus.address, 32'h0);
    checkOutput("midrst_grant_id", 32'(grant_id), 32'd3);
    checkOutput("midrst_locked", 32'(line_locked), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step_cycle();
    checkOutput("midrst_div_write_en", 32'(io_bus.write_en), 32'h1);
    checkOutput("midrst_div_address", io_bus.address, ADDR_DIV);
    checkOutput("midrst_div_data", io_bus.write_data, 32'd27);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
